unidade_controle_multiciclo: RTL

//  Multicycle control FSM for the RV32I subset lw/sw/sub/xor/addi/srl/beq.

---
 rtl/unidade_controle_multiciclo_pkg.sv | 71 +++++++
 rtl/unidade_controle_multiciclo_if.sv | 37 +++
 rtl/unidade_controle_multiciclo_decod_alu.sv | 21 ++
 rtl/unidade_controle_multiciclo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state codes, opcodes,
// funct fields, ALU operation codes and the instruction-class decoder.
package unidade_controle_multiciclo_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EX  = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100,
    ST_FIM = 3'b110
  } estado_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_RSUB,
    CL_RXOR,
    CL_RSRL,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_BEQ
  } classe_e;

  // CL_NONE doubles as the "unsupported encoding" result.
  function automatic classe_e decodificar(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
    classe_e c;
    c = CL_NONE;
    case (opcode)
      OP_R: begin
        if (funct3 == F3_ADD_SUB && funct7 == F7_SUB)
          c = CL_RSUB;
        else if (funct3 == F3_XOR && funct7 == F7_BASE)
          c = CL_RXOR;
        else if (funct3 == F3_SRL && funct7 == F7_BASE)
          c = CL_RSRL;
      end
      OP_I:      if (funct3 == F3_ADD_SUB) c = CL_ADDI;
      OP_LOAD:   if (funct3 == F3_LW)      c = CL_LW;
      OP_STORE:  if (funct3 == F3_SW)      c = CL_SW;
      OP_BRANCH: if (funct3 == F3_BEQ)     c = CL_BEQ;
      default:   c = CL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Bundle between the control unit (slave) and the datapath (master):
// instruction fields and flags in, state code and strobes out.
interface unidade_controle_multiciclo_if;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        zero;
  logic        mem_ready;
  logic [31:0] PC;

  logic [2:0]  estado;
  logic        irwrite;
  logic        pcwrite;
  logic        pcsrc;
  logic        regiwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        alusrc;
  logic [3:0]  alucontrol;
  logic        done;
  logic        illegal;

  modport slave (
    input  opcode, funct3, funct7, zero, mem_ready, PC,
    output estado, irwrite, pcwrite, pcsrc, regiwrite, memread, memwrite,
           memtoreg, alusrc, alucontrol, done, illegal
  );

  modport master (
    output opcode, funct3, funct7, zero, mem_ready, PC,
    input  estado, irwrite, pcwrite, pcsrc, regiwrite, memread, memwrite,
           memtoreg, alusrc, alucontrol, done, illegal
  );

endinterface

// File: rtl/unidade_controle_multiciclo_decod_alu.sv
// Instruction class to ALU operation code; purely combinational so the ALU
// bench can reuse it.
module decod_alu
  import unidade_controle_multiciclo_pkg::*;
(
  input  classe_e    classe,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_NOP;
    case (classe)
      CL_ADDI, CL_LW, CL_SW: alucontrol = ALU_ADD;
      CL_RSUB, CL_BEQ:       alucontrol = ALU_SUB;
      CL_RXOR:               alucontrol = ALU_XOR;
      CL_RSRL:               alucontrol = ALU_SRL;
      default:               alucontrol = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for lw/sw/sub/xor/addi/srl/beq.
// Optional cycle/retired-instruction counters under CONTADOR_CICLOS_EN.
//
// state | meaning
// IF    | fetch: latch IR, PC <= PC+4; PC past program end -> FIM
// ID    | decode class; unsupported encoding -> FIM with illegal set
// EX    | ALU op; BEQ taken writes the branch target here
// MEM   | data memory access, held until mem_ready
// WB    | register file write (ALU or memory data)
// FIM   | halted, done=1 until reset
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
#(
  parameter int unsigned PROG_LEN = 7
) (
  input  logic clk,
  input  logic rst_n,
  unidade_controle_multiciclo_if.slave bus
`ifdef CONTADOR_CICLOS_EN
  ,
  output logic [31:0] ciclos,
  output logic [31:0] retiradas
`endif
);

  localparam logic [31:0] PC_LIMITE = 32'(PROG_LEN * 4);

  estado_e    estado_q, estado_d;
  classe_e    classe_q, classe_d;
  logic       illegal_q, illegal_d;
  logic       regiwrite_q, regiwrite_d;
  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       memtoreg_q, memtoreg_d;
  logic       alusrc_q, alusrc_d;
  logic [3:0] alucontrol_q, alucontrol_d;
  logic       done_q, done_d;
  logic       beq_q, beq_d;

  classe_e    classe_dec;
  logic [3:0] alu_cod;
  logic       pc_ok;
  logic       busca;

  assign classe_dec = decodificar(bus.opcode, bus.funct3, bus.funct7);
  assign pc_ok      = (bus.PC < PC_LIMITE);

  decod_alu u_decod_alu (
    .classe     (classe_d),
    .alucontrol (alu_cod)
  );

  always_comb begin
    estado_d  = estado_q;
    classe_d  = classe_q;
    illegal_d = illegal_q;
    case (estado_q)
      ST_IF:  estado_d = pc_ok ? ST_ID : ST_FIM;
      ST_ID: begin
        if (classe_dec == CL_NONE) begin
          illegal_d = 1'b1;
          classe_d  = CL_NONE;
          estado_d  = ST_FIM;
        end else begin
          classe_d = classe_dec;
          estado_d = ST_EX;
        end
      end
      ST_EX: begin
        case (classe_q)
          CL_LW, CL_SW:                     estado_d = ST_MEM;
          CL_BEQ:                           estado_d = ST_IF;
          CL_RSUB, CL_RXOR, CL_RSRL, CL_ADDI: estado_d = ST_WB;
          default:                          estado_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)
          estado_d = (classe_q == CL_LW) ? ST_WB : ST_IF;
      end
      ST_WB:  estado_d = ST_IF;
      ST_FIM: estado_d = ST_FIM;
      default: estado_d = ST_IF;
    endcase
  end

  // Registered Moore outputs are computed for the state being entered.
  always_comb begin
    alusrc_d     = (estado_d == ST_EX) &&
                   (classe_d == CL_ADDI || classe_d == CL_LW || classe_d == CL_SW);
    alucontrol_d = (estado_d == ST_EX) ? alu_cod : ALU_NOP;
    memread_d    = (estado_d == ST_MEM) && (classe_d == CL_LW);
    memwrite_d   = (estado_d == ST_MEM) && (classe_d == CL_SW);
    regiwrite_d  = (estado_d == ST_WB);
    memtoreg_d   = (estado_d == ST_WB) && (classe_d == CL_LW);
    done_d       = (estado_d == ST_FIM);
    beq_d        = (estado_d == ST_EX) && (classe_d == CL_BEQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= ST_IF;
      classe_q     <= CL_NONE;
      illegal_q    <= 1'b0;
      regiwrite_q  <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      alucontrol_q <= ALU_NOP;
      done_q       <= 1'b0;
      beq_q        <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      classe_q     <= classe_d;
      illegal_q    <= illegal_d;
      regiwrite_q  <= regiwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      memtoreg_q   <= memtoreg_d;
      alusrc_q     <= alusrc_d;
      alucontrol_q <= alucontrol_d;
      done_q       <= done_d;
      beq_q        <= beq_d;
    end
  end

  // The fetch strobes depend on the PC present in IF (a taken branch updates it
  // on the very edge that enters IF), and the branch strobe on the live zero flag.
  // Gating with rst_n keeps every output low while reset is held.
  assign busca = rst_n && (estado_q == ST_IF) && pc_ok;

  assign bus.estado     = estado_q;
  assign bus.irwrite    = busca;
  assign bus.pcwrite    = busca | (beq_q & bus.zero);
  assign bus.pcsrc      = beq_q & bus.zero;
  assign bus.regiwrite  = regiwrite_q;
  assign bus.memread    = memread_q;
  assign bus.memwrite   = memwrite_q;
  assign bus.memtoreg   = memtoreg_q;
  assign bus.alusrc     = alusrc_q;
  assign bus.alucontrol = alucontrol_q;
  assign bus.done       = done_q;
  assign bus.illegal    = illegal_q;

`ifdef CONTADOR_CICLOS_EN
  logic [31:0] ciclos_q, ciclos_d;
  logic [31:0] retiradas_q, retiradas_d;
  logic        retira;

  assign retira = (estado_q == ST_WB) ||
                  (estado_q == ST_MEM && classe_q == CL_SW && bus.mem_ready) ||
                  (estado_q == ST_EX && classe_q == CL_BEQ);

  always_comb begin
    ciclos_d    = ciclos_q;
    retiradas_d = retiradas_q;
    if (estado_q != ST_FIM && ciclos_q != 32'hFFFF_FFFF)
      ciclos_d = ciclos_q + 32'd1;
    if (retira && retiradas_q != 32'hFFFF_FFFF)
      retiradas_d = retiradas_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos_q    <= 32'd0;
      retiradas_q <= 32'd0;
    end else begin
      ciclos_q    <= ciclos_d;
      retiradas_q <= retiradas_d;
    end
  end

  assign ciclos    = ciclos_q;
  assign retiradas = retiradas_q;
`endif

endmodule
